// File: rtl/puf_response_voter_pkg.sv
// -----------------------------------------------------------------------------
// puf_pkg
// Shared definitions for the PUF response majority voter: the controller state
// enum, default parameter values and the helper that sizes the vote counters.
// No ports (package).
// -----------------------------------------------------------------------------
package puf_pkg;

    // Controller states of the voter
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RESTART = 3'd1,
        WAIT    = 3'd2,
        SAMPLE  = 3'd3,
        DONE    = 3'd4
    } voter_state_t;

    // Number of PUF evaluations per vote (odd, 3..15)
    localparam int N_EVAL_DEFAULT  = 7;

    // Maximum number of cycles one WAIT may last when the watchdog is built in
    localparam int TIMEOUT_DEFAULT = 2**20;

    // Width of a counter that must hold every value from 0 to n inclusive
    function automatic int vote_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/puf_response_voter_if.sv
// -----------------------------------------------------------------------------
// puf_response_voter_if
// Groups the request side (start/challenge), the upstream RO PUF connection
// (puf_reset/puf_challenge/puf_response/puf_done) and the result side
// (response/unstable/valid/busy/err) of the voter.
//   slave  : seen by the voter itself
//   master : seen by whatever drives requests and models the PUF
// No ports; clock and reset stay plain ports on the voter.
// -----------------------------------------------------------------------------
interface puf_response_voter_if;
    import puf_pkg::*;

    logic       start;
    logic [7:0] challenge;
    logic [7:0] puf_response;
    logic       puf_done;
    logic       puf_reset;
    logic [7:0] puf_challenge;
    logic [7:0] response;
    logic [7:0] unstable;
    logic       valid;
    logic       busy;
    logic       err;

    modport slave (
        input  start,
        input  challenge,
        input  puf_response,
        input  puf_done,
        output puf_reset,
        output puf_challenge,
        output response,
        output unstable,
        output valid,
        output busy,
        output err
    );

    modport master (
        output start,
        output challenge,
        output puf_response,
        output puf_done,
        input  puf_reset,
        input  puf_challenge,
        input  response,
        input  unstable,
        input  valid,
        input  busy,
        input  err
    );

endinterface

// File: rtl/puf_response_voter_bit_vote_counter.sv
// -----------------------------------------------------------------------------
// bit_vote_counter
// Counts how many evaluations returned 1 for one response bit and derives the
// majority vote and the "evaluations disagreed" flag for that bit.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   clear          : zero the counter (a new vote is accepted)
//   sample         : add bit_in to the counter this cycle
//   bit_in         : the current PUF response bit
//   vote_bit       : majority of the counter value including this cycle's sample
//   unstable_bit   : 1 when that counter value is neither 0 nor N_EVAL
// -----------------------------------------------------------------------------
module bit_vote_counter
    import puf_pkg::*;
#(
    parameter int N_EVAL = N_EVAL_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic sample,
    input  logic bit_in,
    output logic vote_bit,
    output logic unstable_bit
);

    localparam int CW = vote_width(N_EVAL);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (sample) begin
            count_d = count_q + CW'(bit_in);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // The compares look at the value being written so the controller can
    // capture the final result in the same cycle as the last sample.
    assign vote_bit     = (count_d > CW'(N_EVAL / 2));
    assign unstable_bit = (count_d != '0) && (count_d < CW'(N_EVAL));

endmodule

// File: rtl/puf_response_voter.sv
// -----------------------------------------------------------------------------
// puf_response_voter
// Repeatedly evaluates an RO PUF with a latched challenge, restarting it before
// each evaluation, and produces a per-bit majority-voted response plus a per-bit
// flag showing which bits disagreed between evaluations.
// Parameters:
//   N_EVAL         : evaluations per vote (odd, 3..15)
//   TIMEOUT_CYCLES : longest allowed wait for puf_done per evaluation
// Ports:
//   clk, reset     : clock, synchronous active-high reset (also resets the PUF)
//   bus (slave)    : start/challenge request, PUF connection, result outputs
// Build option:
//   PUF_VOTER_TIMEOUT_EN : when defined, a watchdog bounds each WAIT and raises
//                          err on expiry; otherwise err is tied low and WAIT
//                          waits indefinitely.
// -----------------------------------------------------------------------------
module puf_response_voter
    import puf_pkg::*;
#(
    parameter int N_EVAL         = N_EVAL_DEFAULT,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    puf_response_voter_if.slave  bus
);

    localparam int CW = vote_width(N_EVAL);

    voter_state_t  state_q, state_d;
    logic          rst_cnt_q, rst_cnt_d;
    logic [CW-1:0] eval_cnt_q, eval_cnt_d;
    logic [7:0]    challenge_q, challenge_d;
    logic [7:0]    response_q, response_d;
    logic [7:0]    unstable_q, unstable_d;
    logic          valid_q, valid_d;
    logic          puf_reset_q, puf_reset_d;

    logic          start_accept;
    logic          vote_sample;
    logic [7:0]    vote_bits;
    logic [7:0]    unstable_bits;

`ifdef PUF_VOTER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            err_q, err_d;
`endif

    // A request is only taken when no vote is running; start during a vote
    // is dropped on the floor.
    assign start_accept = bus.start && ((state_q == IDLE) || (state_q == DONE));
    assign vote_sample  = (state_q == SAMPLE);

    // One independent counter per response bit
    for (genvar i = 0; i < 8; i++) begin : g_bit
        bit_vote_counter #(
            .N_EVAL (N_EVAL)
        ) u_counter (
            .clk          (clk),
            .reset        (reset),
            .clear        (start_accept),
            .sample       (vote_sample),
            .bit_in       (bus.puf_response[i]),
            .vote_bit     (vote_bits[i]),
            .unstable_bit (unstable_bits[i])
        );
    end

    // Next-state and datapath updates. RESTART lasts two cycles, tracked by
    // rst_cnt. The result registers are loaded in the final SAMPLE cycle so
    // valid rises on the very cycle DONE is entered.
    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        eval_cnt_d  = eval_cnt_q;
        challenge_d = challenge_q;
        response_d  = response_q;
        unstable_d  = unstable_q;
        valid_d     = valid_q;
`ifdef PUF_VOTER_TIMEOUT_EN
        wd_cnt_d    = wd_cnt_q;
        err_d       = err_q;
`endif

        case (state_q)
            IDLE, DONE: begin
                if (start_accept) begin
                    challenge_d = bus.challenge;
                    eval_cnt_d  = '0;
                    rst_cnt_d   = 1'b0;
                    response_d  = '0;
                    unstable_d  = '0;
                    valid_d     = 1'b0;
`ifdef PUF_VOTER_TIMEOUT_EN
                    err_d       = 1'b0;
`endif
                    state_d     = RESTART;
                end
            end

            RESTART: begin
                if (rst_cnt_q) begin
                    rst_cnt_d = 1'b0;
                    state_d   = WAIT;
`ifdef PUF_VOTER_TIMEOUT_EN
                    wd_cnt_d  = '0;
`endif
                end else begin
                    rst_cnt_d = 1'b1;
                end
            end

            WAIT: begin
                if (bus.puf_done) begin
                    state_d = SAMPLE;
                end
`ifdef PUF_VOTER_TIMEOUT_EN
                // The watchdog counts WAIT cycles already spent; the last
                // allowed cycle without puf_done abandons the vote.
                else if (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wd_cnt_d = wd_cnt_q + WD_W'(1);
                end
`endif
            end

            SAMPLE: begin
                eval_cnt_d = eval_cnt_q + CW'(1);
                if (eval_cnt_q == CW'(N_EVAL - 1)) begin
                    response_d = vote_bits;
                    unstable_d = unstable_bits;
                    valid_d    = 1'b1;
                    state_d    = DONE;
                end else begin
                    state_d    = RESTART;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        puf_reset_d = (state_d == RESTART);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers. puf_reset is forced high while reset is applied so
    // the PUF restarts together with the voter.
    always_ff @(posedge clk) begin
        if (reset) begin
            rst_cnt_q   <= 1'b0;
            eval_cnt_q  <= '0;
            challenge_q <= '0;
            response_q  <= '0;
            unstable_q  <= '0;
            valid_q     <= 1'b0;
            puf_reset_q <= 1'b1;
        end else begin
            rst_cnt_q   <= rst_cnt_d;
            eval_cnt_q  <= eval_cnt_d;
            challenge_q <= challenge_d;
            response_q  <= response_d;
            unstable_q  <= unstable_d;
            valid_q     <= valid_d;
            puf_reset_q <= puf_reset_d;
        end
    end

`ifdef PUF_VOTER_TIMEOUT_EN
    // Watchdog and error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            err_q    <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.puf_reset     = puf_reset_q;
    assign bus.puf_challenge = challenge_q;
    assign bus.response      = response_q;
    assign bus.unstable      = unstable_q;
    assign bus.valid         = valid_q;
    assign bus.busy          = (state_q == RESTART) || (state_q == WAIT) ||
                               (state_q == SAMPLE);

endmodule

// File: tb/tb_puf_response_voter.sv
// -----------------------------------------------------------------------------
// tb_puf_response_voter
// Drives the voter with an RO PUF model whose per-evaluation responses come
// from a table and whose puf_done rises a programmable number of cycles after
// puf_reset falls. A timing model derived from the evaluation count and PUF
// latency predicts every output on every cycle of a vote; directed literal
// checks pin the model on the key results.
// -----------------------------------------------------------------------------
module tb_puf_response_voter;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    puf_response_voter_if bus_if ();

    puf_response_voter #(
        .N_EVAL         (7),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // PUF model state
    logic [7:0] pattern [0:14];
    int         lat        = 0;
    int         pulses     = 0;
    int         since_fall = 0;
    bit         puf_dead   = 1'b0;
    logic       prev_rst   = 1'b0;

    // Vote model state
    bit         m_en = 1'b0;
    int         m_start, m_p, m_t;
    logic [7:0] m_resp, m_unst, m_chal;
    logic       prev_valid;
    logic [7:0] prev_resp, prev_unst, prev_chal;
    logic [7:0] vis_chal = 8'h00;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h at cycle %0d",
                     name, actual, expected, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Per-bit majority and disagreement over the first n table entries
    task automatic model_vote(input int n, output logic [7:0] resp,
                              output logic [7:0] unst);
        for (int b = 0; b < 8; b++) begin
            int c;
            c = 0;
            for (int k = 0; k < n; k++) c += int'(pattern[k][b]);
            resp[b] = (c > n / 2);
            unst[b] = (c > 0) && (c < n);
        end
    endtask

    // PUF: restart on puf_reset, report the table entry for the current
    // evaluation lat cycles after puf_reset falls, hold until the next restart.
    always @(posedge clk) begin
        #1;
        if (bus_if.puf_reset === 1'b1) begin
            if (prev_rst !== 1'b1) pulses = pulses + 1;
            since_fall     = 0;
            bus_if.puf_done = 1'b0;
        end else if (puf_dead) begin
            bus_if.puf_done = 1'b0;
        end else if (since_fall >= lat) begin
            bus_if.puf_done     = 1'b1;
            bus_if.puf_response = (pulses >= 1 && pulses <= 15) ? pattern[pulses-1] : 8'h00;
        end else begin
            since_fall = since_fall + 1;
        end
        prev_rst = bus_if.puf_reset;
    end

    // Cycle-by-cycle comparison against the vote model: each evaluation takes
    // 2 restart cycles, lat+1 wait cycles and 1 sample cycle.
    always @(negedge clk) begin
        if (m_en) begin
            int t;
            logic e_busy, e_valid, e_prst;
            logic [7:0] e_resp, e_unst, e_chal;
            t = cyc - m_start;
            if (t == 0) begin
                e_busy = 1'b0; e_valid = prev_valid; e_prst = 1'b0;
                e_resp = prev_resp; e_unst = prev_unst; e_chal = prev_chal;
            end else begin
                e_busy  = (t < m_t);
                e_valid = (t >= m_t);
                e_prst  = (t < m_t) && (((t - 1) % m_p) < 2);
                e_resp  = e_valid ? m_resp : 8'h00;
                e_unst  = e_valid ? m_unst : 8'h00;
                e_chal  = m_chal;
            end
            check_output("model_busy",      bus_if.busy,          e_busy);
            check_output("model_valid",     bus_if.valid,         e_valid);
            check_output("model_puf_reset", bus_if.puf_reset,     e_prst);
            check_output("model_response",  bus_if.response,      e_resp);
            check_output("model_unstable",  bus_if.unstable,      e_unst);
            check_output("model_challenge", bus_if.puf_challenge, e_chal);
            check_output("model_err",       bus_if.err,           1'b0);
        end
    end

    // Issues a one-cycle start and arms the model; returns in the cycle after
    task automatic apply_stimulus(input logic [7:0] chal, input int l);
        if (m_en && (cyc - m_start) >= m_t) begin
            prev_valid = 1'b1; prev_resp = m_resp; prev_unst = m_unst;
        end else begin
            prev_valid = 1'b0; prev_resp = 8'h00; prev_unst = 8'h00;
        end
        prev_chal = vis_chal;
        vis_chal  = chal;
        m_chal    = chal;
        lat       = l;
        pulses    = 0;
        m_p       = 4 + l;
        m_t       = 7 * m_p + 1;
        model_vote(7, m_resp, m_unst);
        m_start   = cyc;
        m_en      = 1'b1;
        bus_if.start     = 1'b1;
        bus_if.challenge = chal;
        tick();
        bus_if.start     = 1'b0;
        bus_if.challenge = 8'hEE;
    endtask

    // Waits (bounded) for valid; leaves the caller at the negedge it was seen
    task automatic wait_valid(output int latency);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 300 && !seen; n++) begin
            @(negedge clk);
            if (bus_if.valid === 1'b1) seen = 1'b1;
        end
        if (!seen) check_output("valid_wait", 0, 1);
        latency = cyc - m_start;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: got no finish want finish");
        $fatal(1, "[TB] bench did not finish");
    end

    initial begin
        int latency;
        int s;

        reset               = 1'b1;
        bus_if.start        = 1'b0;
        bus_if.challenge    = 8'h00;
        bus_if.puf_done     = 1'b0;
        bus_if.puf_response = 8'h00;
        for (int k = 0; k < 15; k++) pattern[k] = 8'h00;

        // Reset state
        @(posedge clk);
        @(negedge clk);
        check_output("rst_puf_reset", bus_if.puf_reset,     1'b1);
        check_output("rst_busy",      bus_if.busy,          1'b0);
        check_output("rst_valid",     bus_if.valid,         1'b0);
        check_output("rst_response",  bus_if.response,      8'h00);
        check_output("rst_unstable",  bus_if.unstable,      8'h00);
        check_output("rst_challenge", bus_if.puf_challenge, 8'h00);
        check_output("rst_err",       bus_if.err,           1'b0);
        tick();
        reset = 1'b0;
        tick();
        tick();

        // Stable PUF: every evaluation returns A5
        $display("[TB] stable PUF, challenge 3C");
        for (int k = 0; k < 15; k++) pattern[k] = 8'hA5;
        apply_stimulus(8'h3C, 2);
        wait_valid(latency);
        check_output("a_latency",   latency,              43);
        check_output("a_response",  bus_if.response,      8'hA5);
        check_output("a_unstable",  bus_if.unstable,      8'h00);
        check_output("a_valid",     bus_if.valid,         1'b1);
        check_output("a_challenge", bus_if.puf_challenge, 8'h3C);
        check_output("a_pulses",    pulses,               7);

        // Start right after valid rises; 4 of 7 evaluations are FF
        $display("[TB] back-to-back start, 4xFF 3x00");
        tick();
        pattern[0] = 8'hFF; pattern[1] = 8'h00; pattern[2] = 8'hFF; pattern[3] = 8'h00;
        pattern[4] = 8'hFF; pattern[5] = 8'h00; pattern[6] = 8'hFF;
        apply_stimulus(8'h5A, 0);
        @(negedge clk);
        check_output("b_valid_drop", bus_if.valid, 1'b0);
        check_output("b_busy_rise",  bus_if.busy,  1'b1);
        wait_valid(latency);
        check_output("b_latency",  latency,         29);
        check_output("b_response", bus_if.response, 8'hFF);
        check_output("b_unstable", bus_if.unstable, 8'hFF);
        repeat (5) tick();

        // Start during the third evaluation must be ignored
        $display("[TB] start ignored while busy");
        pattern[0] = 8'h0F; pattern[1] = 8'h0F; pattern[2] = 8'h0E; pattern[3] = 8'h1F;
        pattern[4] = 8'h0F; pattern[5] = 8'h8F; pattern[6] = 8'h0F;
        apply_stimulus(8'hC3, 1);
        repeat (12) tick();
        bus_if.start     = 1'b1;
        bus_if.challenge = 8'h99;
        tick();
        bus_if.start     = 1'b0;
        wait_valid(latency);
        check_output("c_latency",   latency,              36);
        check_output("c_response",  bus_if.response,      8'h0F);
        check_output("c_unstable",  bus_if.unstable,      8'h91);
        check_output("c_challenge", bus_if.puf_challenge, 8'hC3);
        check_output("c_pulses",    pulses,               7);
        repeat (3) tick();

        // Reset in the fifth WAIT, with a competing start in the same cycle
        $display("[TB] reset mid-vote");
        for (int k = 0; k < 15; k++) pattern[k] = 8'h5A;
        apply_stimulus(8'h77, 1);
        repeat (22) tick();
        m_en             = 1'b0;
        reset            = 1'b1;
        bus_if.start     = 1'b1;
        bus_if.challenge = 8'hEE;
        tick();
        reset        = 1'b0;
        bus_if.start = 1'b0;
        vis_chal     = 8'h00;
        @(negedge clk);
        check_output("d_puf_reset", bus_if.puf_reset,     1'b1);
        check_output("d_busy",      bus_if.busy,          1'b0);
        check_output("d_valid",     bus_if.valid,         1'b0);
        check_output("d_response",  bus_if.response,      8'h00);
        check_output("d_unstable",  bus_if.unstable,      8'h00);
        check_output("d_challenge", bus_if.puf_challenge, 8'h00);
        check_output("d_err",       bus_if.err,           1'b0);
        tick();
        @(negedge clk);
        check_output("d_puf_reset_off", bus_if.puf_reset, 1'b0);
        check_output("d_idle_busy",     bus_if.busy,      1'b0);
        tick();

        // Fresh vote after the abort
        $display("[TB] vote after reset");
        pattern[0] = 8'h81; pattern[1] = 8'h81; pattern[2] = 8'h80; pattern[3] = 8'h01;
        pattern[4] = 8'h81; pattern[5] = 8'h81; pattern[6] = 8'h00;
        apply_stimulus(8'hE7, 0);
        wait_valid(latency);
        check_output("e_latency",  latency,         29);
        check_output("e_response", bus_if.response, 8'h81);
        check_output("e_unstable", bus_if.unstable, 8'h81);
        repeat (2) tick();

`ifdef PUF_VOTER_TIMEOUT_EN
        // Dead PUF: the watchdog fires 100 cycles after WAIT entry
        $display("[TB] watchdog timeout");
        m_en             = 1'b0;
        puf_dead         = 1'b1;
        bus_if.start     = 1'b1;
        bus_if.challenge = 8'h42;
        s = cyc;
        tick();
        bus_if.start = 1'b0;
        repeat (101) tick();
        @(negedge clk);
        check_output("t_cycle",      cyc - s,    102);
        check_output("t_err_before", bus_if.err, 1'b0);
        check_output("t_busy_before", bus_if.busy, 1'b1);
        tick();
        @(negedge clk);
        check_output("t_err",      bus_if.err,      1'b1);
        check_output("t_busy",     bus_if.busy,     1'b0);
        check_output("t_valid",    bus_if.valid,    1'b0);
        check_output("t_response", bus_if.response, 8'h00);
        puf_dead = 1'b0;
`else
        s = cyc;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/puf_response_voter.md
PUF_RESPONSE_VOTER -- requirements
Module: puf_response_voter

Interface
REQ-001 The block SHALL use parameter N_EVAL, default 7, meaning the number of PUF evaluations per vote (odd, 3..15).
REQ-002 The block SHALL use parameter TIMEOUT_CYCLES, default 2**20, meaning the maximum wait for PUF_DONE per evaluation.
REQ-003 CLK  input  1  the single clock; all logic SHALL be on the rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 START  input  1  a one-cycle request to begin a vote.
REQ-006 CHALLENGE  input  8  the challenge to evaluate, sampled when START is accepted.
REQ-007 PUF_RESPONSE  input  8  the raw response from the upstream RO PUF.
REQ-008 PUF_DONE  input  1  the upstream completion flag, level, high while PUF_RESPONSE is valid.
REQ-009 PUF_RESET  output  1  the restart pulse to the upstream PUF RESET.
REQ-010 PUF_CHALLENGE  output  8  the latched challenge, driven to the upstream PUF.
REQ-011 RESPONSE  output  8  the per-bit majority-voted response.
REQ-012 UNSTABLE  output  8  per-bit flag, set when the evaluations of that bit disagreed.
REQ-013 VALID  output  1  high while RESPONSE and UNSTABLE hold a completed vote.
REQ-014 BUSY  output  1  high while a vote is in progress.
REQ-015 ERR  output  1  the timeout flag; see REQ-030.

Function
REQ-016 The FSM SHALL have the states IDLE, RESTART, WAIT, SAMPLE and DONE.
REQ-017 In IDLE or DONE, when START=1, the block SHALL latch CHALLENGE into PUF_CHALLENGE, clear the vote counters, evaluation count, VALID and ERR, and go to RESTART.
REQ-018 START while BUSY=1 SHALL be ignored, and the latched challenge SHALL stay unchanged.
REQ-019 RESTART SHALL drive PUF_RESET=1 for exactly 2 cycles and then go to WAIT.
REQ-020 In WAIT, the first cycle with PUF_DONE=1 SHALL move the FSM to SAMPLE.
REQ-021 In SAMPLE (one cycle), the block SHALL add PUF_RESPONSE[i] into an independent per-bit counter i (width clog2(N_EVAL+1)) and increment the evaluation count.
REQ-022 After SAMPLE, if the evaluation count is below N_EVAL, the FSM SHALL go to RESTART; otherwise it SHALL go to DONE.
REQ-023 On entry to DONE, RESPONSE[i] SHALL be 1 if and only if count[i] > N_EVAL/2 (integer division).
REQ-024 On entry to DONE, UNSTABLE[i] SHALL be 1 if and only if 0 < count[i] < N_EVAL.
REQ-025 On entry to DONE, VALID SHALL rise to 1.
REQ-026 VALID, RESPONSE and UNSTABLE SHALL hold in DONE until the next accepted START, then clear in the same cycle.
REQ-027 BUSY SHALL be 1 exactly in RESTART, WAIT and SAMPLE.
REQ-028 PUF_RESET SHALL be 0 in all states other than RESTART.
REQ-029 With an ideal PUF (PUF_DONE high L cycles after PUF_RESET falls), the latency from START to VALID SHALL be N_EVAL*(2+L+2)+1 cycles.
REQ-030 If TIMEOUT_EN is compiled in and a WAIT lasts TIMEOUT_CYCLES cycles, the block SHALL set ERR=1, leave RESPONSE at 0 with VALID=0, and go to IDLE.

Reset
REQ-031 On RESET=1, the FSM SHALL go to IDLE.
REQ-032 On RESET=1, RESPONSE, UNSTABLE, PUF_CHALLENGE, all counters, VALID, BUSY and ERR SHALL be set to 0.
REQ-033 On RESET=1, PUF_RESET SHALL be driven 1, so the PUF is reset together with this block.
REQ-034 RESET mid-vote SHALL abort the vote with no partial result visible.
REQ-035 RESET SHALL take priority over START in the same cycle.

Configuration
REQ-036 The macro PUF_VOTER_TIMEOUT_EN SHALL compile the WAIT watchdog counter in or out.
REQ-037 With PUF_VOTER_TIMEOUT_EN defined, REQ-030 SHALL apply.
REQ-038 Without PUF_VOTER_TIMEOUT_EN, no watchdog counter SHALL exist, ERR SHALL be tied to 0, and WAIT SHALL wait indefinitely.

Structure
REQ-039 The shared package puf_pkg SHALL hold the state enum voter_state_t, N_EVAL_DEFAULT, TIMEOUT_DEFAULT and the function vote_width(n) returning clog2(n+1).
REQ-040 The sub-module bit_vote_counter SHALL hold one counter, the majority compare and the unstable compare, and SHALL be instantiated 8 times.

Verification
REQ-041 The bench SHALL cover: a PUF model always returning 8'hA5, CHALLENGE=8'h3C, START -> PUF_CHALLENGE=8'h3C, 7 PUF_RESET pulses, RESPONSE=8'hA5, UNSTABLE=8'h00, VALID=1.
REQ-042 The bench SHALL cover: a model returning 8'hFF on 4 of 7 evaluations and 8'h00 on 3 -> RESPONSE=8'hFF, UNSTABLE=8'hFF.
REQ-043 The bench SHALL cover: START pulsed again during the 3rd evaluation -> the vote is unaffected, exactly 7 evaluations occur and PUF_CHALLENGE is unchanged.
REQ-044 The bench SHALL cover: RESET asserted during the 5th WAIT -> the next cycle shows all outputs 0, the FSM in IDLE and PUF_RESET=1.
REQ-045 The bench SHALL cover: with PUF_VOTER_TIMEOUT_EN, TIMEOUT_CYCLES=100 and PUF_DONE held at 0 -> ERR=1 exactly 100 cycles after WAIT entry, VALID=0 and BUSY=0.
REQ-046 The bench SHALL cover: START in the cycle after VALID rises -> VALID drops that cycle and a new vote begins.
